// File: rtl/vram_blit_ctrl.sv
// Display VRAM sequencer and arbiter: runs clear/scroll commands as per-pixel
// read-modify-write sequences and shares the single VRAM port with the CPU.
module vram_blit_ctrl #(
  parameter int HW = 7,
  parameter int VW = 6,
  parameter int PW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [3:0]    cmd_n,
  input  logic [PW-1:0] cmd_planes,
  input  logic          hires,
  input  logic          cpu_req,
  output logic          cpu_gnt,
  input  logic [HW-1:0] cpu_hpos,
  input  logic [VW-1:0] cpu_vpos,
  input  logic [PW-1:0] cpu_pixeli,
  input  logic          cpu_we,
  output logic [PW-1:0] cpu_pixelo,
  output logic [HW-1:0] vram_hpos,
  output logic [VW-1:0] vram_vpos,
  output logic [PW-1:0] vram_pixeli,
  output logic          vram_we,
  input  logic [PW-1:0] vram_pixelo,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, S0, S1, S2} state_e;

  localparam logic [2:0] OP_CLEAR = 3'd0;
  localparam logic [2:0] OP_DOWN  = 3'd1;
  localparam logic [2:0] OP_UP    = 3'd2;
  localparam logic [2:0] OP_RIGHT = 3'd3;
  localparam logic [2:0] OP_LEFT  = 3'd4;

  state_e        state_q, state_d;
  logic [HW-1:0] x_q, x_d;
  logic [VW-1:0] y_q, y_d;
  logic [2:0]    op_q, op_d;
  logic [3:0]    n_q, n_d;
  logic [PW-1:0] planes_q, planes_d;
  logic          hires_q, hires_d;
  logic [PW-1:0] src_q, src_d;
  logic          done_q, done_d;

  logic [HW-1:0] x_max, x_top_in;
  logic [VW-1:0] y_max, y_top_in;
  logic          desc, desc_in, last_px;
  logic [HW:0]   src_x_e;
  logic [VW:0]   src_y_e;
  logic          src_ok;
  logic [PW-1:0] new_pix;

  assign x_max    = hires_q ? '1 : {1'b0, {(HW-1){1'b1}}};
  assign y_max    = hires_q ? '1 : {1'b0, {(VW-1){1'b1}}};
  assign x_top_in = hires   ? '1 : {1'b0, {(HW-1){1'b1}}};
  assign y_top_in = hires   ? '1 : {1'b0, {(VW-1){1'b1}}};
  assign desc     = (op_q == OP_DOWN) || (op_q == OP_RIGHT);
  assign desc_in  = (cmd_op == OP_DOWN) || (cmd_op == OP_RIGHT);
  assign last_px  = desc ? (x_q == '0 && y_q == '0) : (x_q == x_max && y_q == y_max);
  assign new_pix  = (src_q & planes_q) | (vram_pixelo & ~planes_q);

  // Source coordinate is one bit wider than the screen so range checks never wrap.
  always_comb begin
    src_x_e = {1'b0, x_q};
    src_y_e = {1'b0, y_q};
    src_ok  = 1'b0;
    case (op_q)
      OP_DOWN: begin
        src_y_e = {1'b0, y_q} - (VW+1)'(n_q);
        src_ok  = {1'b0, y_q} >= (VW+1)'(n_q);
      end
      OP_UP: begin
        src_y_e = {1'b0, y_q} + (VW+1)'(n_q);
        src_ok  = src_y_e <= {1'b0, y_max};
      end
      OP_RIGHT: begin
        src_x_e = {1'b0, x_q} - (HW+1)'(4);
        src_ok  = {1'b0, x_q} >= (HW+1)'(4);
      end
      OP_LEFT: begin
        src_x_e = {1'b0, x_q} + (HW+1)'(4);
        src_ok  = src_x_e <= {1'b0, x_max};
      end
      default: ;
    endcase
  end

  // NOTE: reset is sampled on the clock edge; the pixel memory lives outside
  // this block, so only the small control registers need a reset value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      op_q     <= '0;
      n_q      <= '0;
      planes_q <= '0;
      hires_q  <= 1'b0;
      src_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register updates from pre-edge values.
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      op_q     <= op_d;
      n_q      <= n_d;
      planes_q <= planes_d;
      hires_q  <= hires_d;
      src_q    <= src_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path infers a latch.
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    op_d     = op_q;
    n_d      = n_q;
    planes_d = planes_q;
    hires_d  = hires_q;
    src_d    = src_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid) begin
        op_d     = cmd_op;
        n_d      = cmd_n;
        planes_d = cmd_planes;
        hires_d  = hires;
        if (cmd_op > OP_LEFT) begin
          done_d = 1'b1;
        end else begin
          state_d = S0;
          x_d     = desc_in ? x_top_in : '0;
          y_d     = desc_in ? y_top_in : '0;
        end
      end
      S0: if (!cpu_gnt) state_d = S1;
      S1: begin
        state_d = S2;
        src_d   = src_ok ? vram_pixelo : '0;
      end
      S2: begin
        if (last_px) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S0;
          if (desc) begin
            x_d = (x_q == '0) ? x_max : x_q - 1'b1;
            y_d = (x_q == '0) ? y_q - 1'b1 : y_q;
          end else begin
            x_d = (x_q == x_max) ? '0 : x_q + 1'b1;
            y_d = (x_q == x_max) ? y_q + 1'b1 : y_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The CPU only wins the port at pixel boundaries, never mid read-modify-write.
  always_comb begin
    cmd_ready   = (state_q == IDLE);
    busy        = (state_q != IDLE);
    done        = done_q;
    cpu_gnt     = cpu_req && (state_q == IDLE || state_q == S0);
    cpu_pixelo  = vram_pixelo;
    vram_hpos   = '0;
    vram_vpos   = '0;
    vram_pixeli = '0;
    vram_we     = 1'b0;
    if (cpu_gnt) begin
      vram_hpos   = cpu_hpos;
      vram_vpos   = cpu_vpos;
      vram_pixeli = cpu_pixeli;
      vram_we     = cpu_we;
    end else begin
      case (state_q)
        S0: begin
          vram_hpos = src_x_e[HW-1:0];
          vram_vpos = src_y_e[VW-1:0];
        end
        S1: begin
          vram_hpos = x_q;
          vram_vpos = y_q;
        end
        S2: begin
          vram_hpos   = x_q;
          vram_vpos   = y_q;
          vram_pixeli = new_pix;
          vram_we     = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_blit_ctrl.sv
// Bench for vram_blit_ctrl: behavioural VRAM, idle arbitration vector table,
// and whole-command sequences compared against a reference scroll model.
module tb_vram_blit_ctrl;
  localparam int HW = 7;
  localparam int VW = 6;
  localparam int PW = 2;

  logic          clk, reset, cmd_valid, cmd_ready, hires, cpu_req, cpu_gnt, cpu_we;
  logic [2:0]    cmd_op;
  logic [3:0]    cmd_n;
  logic [PW-1:0] cmd_planes, cpu_pixeli, cpu_pixelo, vram_pixeli, vram_pixelo;
  logic [HW-1:0] cpu_hpos, vram_hpos;
  logic [VW-1:0] cpu_vpos, vram_vpos;
  logic          vram_we, busy, done;

  vram_blit_ctrl #(.HW(HW), .VW(VW), .PW(PW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_n(cmd_n), .cmd_planes(cmd_planes), .hires(hires),
    .cpu_req(cpu_req), .cpu_gnt(cpu_gnt), .cpu_hpos(cpu_hpos), .cpu_vpos(cpu_vpos),
    .cpu_pixeli(cpu_pixeli), .cpu_we(cpu_we), .cpu_pixelo(cpu_pixelo),
    .vram_hpos(vram_hpos), .vram_vpos(vram_vpos), .vram_pixeli(vram_pixeli),
    .vram_we(vram_we), .vram_pixelo(vram_pixelo), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [PW-1:0] mem  [0:63][0:127];
  logic [PW-1:0] snap [0:63][0:127];
  logic [PW-1:0] expi [0:63][0:127];
  int wr_cnt = 0;

  always @(posedge clk) begin
    if (vram_we) begin
      mem[vram_vpos][vram_hpos] <= vram_pixeli;
      wr_cnt <= wr_cnt + 1;
    end
    vram_pixelo <= mem[vram_vpos][vram_hpos];
  end

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic req; int h; int v; int p; logic we;
    logic egnt; int eh; int ev; int ep; logic ewe;
  } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic fill(input int x0, input int y0, input int w, input int h, input int val);
    for (int y = y0; y < y0 + h; y++)
      for (int x = x0; x < x0 + w; x++) begin
        tick();
        cpu_req = 1'b1; cpu_we = 1'b1;
        cpu_hpos = HW'(x); cpu_vpos = VW'(y); cpu_pixeli = PW'(val);
      end
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  // Reference result: out-of-place scroll of the current screen.
  task automatic ref_cmd(input int op, input int n, input int planes, input bit hi);
    int w, h, sx, sy, s;
    bit ok;
    w = hi ? 128 : 64;
    h = hi ? 64 : 32;
    for (int y = 0; y < 64; y++)
      for (int x = 0; x < 128; x++) snap[y][x] = mem[y][x];
    for (int y = 0; y < 64; y++)
      for (int x = 0; x < 128; x++) begin
        expi[y][x] = snap[y][x];
        if (op <= 4 && x < w && y < h) begin
          sx = x; sy = y; ok = 1'b0;
          case (op)
            1: begin sy = y - n; ok = (y >= n); end
            2: begin sy = y + n; ok = (y + n <= h - 1); end
            3: begin sx = x - 4; ok = (x >= 4); end
            4: begin sx = x + 4; ok = (x + 4 <= w - 1); end
            default: ok = 1'b0;
          endcase
          s = ok ? int'(snap[sy][sx]) : 0;
          expi[y][x] = PW'((s & planes) | (int'(snap[y][x]) & ~planes));
        end
      end
  endtask

  task automatic check_image(input string name);
    int bad = 0;
    for (int y = 0; y < 64; y++)
      for (int x = 0; x < 128; x++)
        if (mem[y][x] !== expi[y][x]) bad++;
    check(name, bad, 0);
  endtask

  task automatic issue(input int op, input int n, input int planes, input bit hi, output int t);
    tick();
    cmd_valid = 1'b1; cmd_op = 3'(op); cmd_n = 4'(n); cmd_planes = PW'(planes); hires = hi;
    @(negedge clk);
    check("cmd_ready_at_accept", cmd_ready, 1);
    t = cyc;
    tick();
    cmd_valid = 1'b0; cmd_op = 3'd7; cmd_n = 4'd15; cmd_planes = '0; hires = ~hi;
  endtask

  task automatic wait_done(input int t, output int lat);
    lat = -1;
    for (int i = 0; i < 30000; i++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc - t;
        break;
      end
      tick();
    end
    tick();
    @(negedge clk);
    check("done_single_pulse", done, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t, lat, w0, w1, grants, pulses;
    vecs[0] = '{1'b1, 5,   3,  2, 1'b1, 1'b1, 5,   3,  2, 1'b1};
    vecs[1] = '{1'b0, 5,   3,  2, 1'b1, 1'b0, 0,   0,  0, 1'b0};
    vecs[2] = '{1'b1, 127, 63, 3, 1'b0, 1'b1, 127, 63, 3, 1'b0};
    vecs[3] = '{1'b1, 0,   0,  1, 1'b1, 1'b1, 0,   0,  1, 1'b1};
    vecs[4] = '{1'b0, 127, 63, 3, 1'b1, 1'b0, 0,   0,  0, 1'b0};

    reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_n = '0; cmd_planes = '0; hires = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_hpos = '0; cpu_vpos = '0; cpu_pixeli = '0;
    repeat (2) tick();
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_vram_we", vram_we, 0);
    check("rst_vram_addr", {vram_vpos, vram_hpos}, 0);
    check("rst_gnt_low", cpu_gnt, 0);
    tick();
    cpu_req = 1'b1;
    @(negedge clk);
    check("rst_gnt_follows_req", cpu_gnt, 1);
    tick();
    reset = 1'b1; cpu_req = 1'b0;

    for (int i = 0; i < 5; i++) begin
      tick();
      cpu_req = vecs[i].req; cpu_we = vecs[i].we;
      cpu_hpos = HW'(vecs[i].h); cpu_vpos = VW'(vecs[i].v); cpu_pixeli = PW'(vecs[i].p);
      @(negedge clk);
      check($sformatf("vec%0d_gnt", i), cpu_gnt, vecs[i].egnt);
      check($sformatf("vec%0d_hpos", i), vram_hpos, vecs[i].eh);
      check($sformatf("vec%0d_vpos", i), vram_vpos, vecs[i].ev);
      check($sformatf("vec%0d_we", i), vram_we, vecs[i].ewe);
      if (vecs[i].egnt) check($sformatf("vec%0d_pix", i), vram_pixeli, vecs[i].ep);
    end
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_hpos = 7'd5; cpu_vpos = 6'd3;
    tick();
    cpu_req = 1'b0;
    @(negedge clk);
    check("cpu_pixelo_readback", cpu_pixelo, 2);

    // NOP opcodes: done one cycle after accept, no writes.
    w0 = wr_cnt;
    issue(5, 0, 3, 1'b1, t);
    wait_done(t, lat);
    check("nop5_latency", lat, 1);
    issue(7, 0, 3, 1'b0, t);
    wait_done(t, lat);
    check("nop7_latency", lat, 1);
    check("nop_no_writes", wr_cnt - w0, 0);

    // CLEAR hires over a screen full of 3.
    fill(0, 0, 128, 64, 3);
    ref_cmd(0, 0, 3, 1'b1);
    issue(0, 0, 3, 1'b1, t);
    wait_done(t, lat);
    check("clear_latency", lat, 24577);
    check("clear_px_0_0", mem[0][0], 0);
    check("clear_px_127_63", mem[63][127], 0);
    check_image("clear_image");

    // SCROLL_DOWN n=1 hires, plane 0 only.
    fill(5, 0, 1, 1, 3);
    ref_cmd(1, 1, 1, 1'b1);
    issue(1, 1, 1, 1'b1, t);
    wait_done(t, lat);
    check("down_latency", lat, 24577);
    check("down_px_5_0", mem[0][5], 2);
    check("down_px_5_1", mem[1][5], 1);
    check_image("down_image");

    // SCROLL_LEFT lores, both planes.
    fill(10, 3, 1, 1, 1);
    fill(100, 3, 1, 1, 2);
    fill(62, 3, 1, 1, 3);
    ref_cmd(4, 0, 3, 1'b0);
    issue(4, 0, 3, 1'b0, t);
    wait_done(t, lat);
    check("left_latency", lat, 6145);
    check("left_px_6_3", mem[3][6], 1);
    check("left_px_10_3", mem[3][10], 0);
    check("left_px_62_3", mem[3][62], 0);
    check("left_px_100_3", mem[3][100], 2);
    check_image("left_image");

    // SCROLL_RIGHT lores with a CPU request raised mid-pixel (S1 of pixel 10).
    fill(0, 0, 1, 1, 3);
    fill(20, 5, 1, 1, 3);
    fill(63, 31, 1, 1, 2);
    ref_cmd(3, 0, 2, 1'b0);
    issue(3, 0, 2, 1'b0, t);
    while (cyc < t + 32) tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_hpos = 7'd7; cpu_vpos = 6'd9;
    @(negedge clk);
    check("stall_no_gnt_s1", cpu_gnt, 0);
    tick();
    @(negedge clk);
    check("stall_no_gnt_s2", cpu_gnt, 0);
    check("stall_engine_writes_s2", vram_we, 1);
    grants = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      @(negedge clk);
      if (cpu_gnt) begin
        if (grants == 0) check("stall_cpu_addr", vram_hpos, 7);
        grants++;
      end
      if (grants == 5) break;
    end
    tick();
    cpu_req = 1'b0;
    check("stall_grant_cycles", grants, 5);
    wait_done(t, lat);
    check("stall_latency", lat, 6150);
    check_image("stall_image");

    // Reset 100 cycles into a lores CLEAR.
    w0 = wr_cnt;
    issue(0, 0, 3, 1'b0, t);
    while (cyc < t + 100) tick();
    reset = 1'b0;
    w1 = wr_cnt;
    tick();
    @(negedge clk);
    check("midrst_cmd_ready", cmd_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_vram_we", vram_we, 0);
    check("midrst_done", done, 0);
    check("midrst_writes_before", w1 - w0, 33);
    tick();
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      if (done) pulses++;
    end
    check("midrst_no_done", pulses, 0);
    check("midrst_no_more_writes", wr_cnt - w1, 0);

    ref_cmd(2, 0, 3, 1'b0);
    issue(2, 0, 3, 1'b0, t);
    wait_done(t, lat);
    check("up0_latency", lat, 6145);
    check_image("up0_image");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
